// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: accepts a 24-bit target colour, ramps each channel one LSB per
// step toward it, and drives active-low LED pins with glitch-free per-channel PWM.

module rgb_pwm_fader_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                reload,
    input  logic [PWM_BITS-1:0] tgt_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                match_next,
    output logic                pin
);
    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] lvl_step;

    // One LSB toward the target; equal channels hold, so levels never wrap.
    always_comb begin
        lvl_step = level;
        if (level < tgt)
            lvl_step = level + PWM_BITS'(1);
        else if (level > tgt)
            lvl_step = level - PWM_BITS'(1);
    end

    assign match_next = (lvl_step == tgt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt   <= '0;
            level <= '0;
            duty  <= '0;
            pin   <= 1'b1;
        end else begin
            if (load)
                tgt <= tgt_in;
            if (step)
                level <= lvl_step;
            // Duty only changes at the period boundary so a period is never split.
            if (reload)
                duty <= level;
            pin <= !(pwm_cnt < duty);
        end
    end
endmodule

module rgb_pwm_fader #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_TICKS = 46875
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PWM_BITS-1:0]   target_r,
    input  logic [PWM_BITS-1:0]   target_g,
    input  logic [PWM_BITS-1:0]   target_b,
    input  logic                  target_valid,
    output logic                  target_ready,
    output logic                  busy,
    output logic [3*PWM_BITS-1:0] level,
    output logic                  RGB_R,
    output logic                  RGB_G,
    output logic                  RGB_B
);
    localparam int NUM_LANES = 3;
    localparam int TW = $clog2(STEP_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    typedef enum logic {IDLE, FADE} state_t;

    state_t                               state, state_nxt;
    logic [TW-1:0]                        tick;
    logic [PWM_BITS-1:0]                  pwm_cnt;
    logic [NUM_LANES-1:0][PWM_BITS-1:0]   tgt_bus;
    logic [NUM_LANES-1:0][PWM_BITS-1:0]   lvl_bus;
    logic [NUM_LANES-1:0]                 match_next;
    logic [NUM_LANES-1:0]                 pin;
    logic                                 accept;
    logic                                 tgt_eq;
    logic                                 step;
    logic                                 reload;

    // Lane 2 is red, lane 0 is blue, matching the {r,g,b} packing of level.
    assign tgt_bus = {target_r, target_g, target_b};
    assign level   = lvl_bus;
    assign RGB_R   = pin[2];
    assign RGB_G   = pin[1];
    assign RGB_B   = pin[0];

    assign target_ready = (state == IDLE);
    assign busy         = (state == FADE);
    assign accept       = target_valid && target_ready;
    assign tgt_eq       = (tgt_bus == lvl_bus);
    assign step         = (state == FADE) && (tick == TICK_LAST);
    assign reload       = &pwm_cnt;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            rgb_pwm_fader_lane #(.PWM_BITS(PWM_BITS)) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (accept),
                .step       (step),
                .reload     (reload),
                .tgt_in     (tgt_bus[i]),
                .pwm_cnt    (pwm_cnt),
                .level      (lvl_bus[i]),
                .match_next (match_next[i]),
                .pin        (pin[i])
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !tgt_eq) state_nxt = FADE;
            FADE: if (step && (&match_next)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Tick counter sits at 0 while idle, so every fade starts a full step interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick <= '0;
        else if (state != FADE || step)
            tick <= '0;
        else
            tick <= tick + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with STEP_TICKS = 4.
module tb_rgb_pwm_fader;
    localparam int PW = 8;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] tr = '0, tg = '0, tb = '0;
    logic          tv = 1'b0;
    logic          target_ready, busy;
    logic [3*PW-1:0] level;
    logic          RGB_R, RGB_G, RGB_B;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_pwm_fader #(.PWM_BITS(PW), .STEP_TICKS(ST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_r     (tr),
        .target_g     (tg),
        .target_b     (tb),
        .target_valid (tv),
        .target_ready (target_ready),
        .busy         (busy),
        .level        (level),
        .RGB_R        (RGB_R),
        .RGB_G        (RGB_G),
        .RGB_B        (RGB_B)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a target at a negedge and hold valid until the edge that accepts it.
    task automatic send(input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        tr = r; tg = g; tb = b; tv = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            ok = target_ready;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        #1 tv = 1'b0;
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic count_low(input int len, output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            r += int'(!RGB_R); g += int'(!RGB_G); b += int'(!RGB_B);
        end
    endtask

    initial begin
        int  n, lr, lg, lb, lo;
        bit  found, prev, rdy_leak;

        // Asynchronous reset asserted mid-cycle
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_pins",  32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(target_ready), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        count_low(1024, lr, lg, lb);
        check("idle_no_pulse", 32'(lr + lg + lb), 32'd0);

        // Single fade 0 -> 255 on red: 255 steps * 4 cycles
        send(8'd255, 8'd0, 8'd0);
        @(negedge clk);
        check("fade1_busy_rise", 32'(busy), 32'd1);
        wait_idle(n);
        check("fade1_len", 32'(n + 1), 32'd1020);
        check("fade1_level", 32'(level), 32'hFF0000);
        repeat (512) @(negedge clk);
        count_low(256, lr, lg, lb);
        check("fade1_r_low", 32'(lr), 32'd255);
        check("fade1_g_low", 32'(lg), 32'd0);
        check("fade1_b_low", 32'(lb), 32'd0);

        // Mixed direction from {200,0,50} to {100,10,50}
        send(8'd200, 8'd0, 8'd50);
        wait_idle(n);
        check("mix_start", 32'(level), {8'd0, 8'd200, 8'd0, 8'd50});
        send(8'd100, 8'd10, 8'd50);
        n = 0;
        for (int k = 1; k < 5000; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (k == 21)  check("mix_k21",  32'(level), {8'd0, 8'd195, 8'd5,  8'd50});
            if (k == 41)  check("mix_k41",  32'(level), {8'd0, 8'd190, 8'd10, 8'd50});
            if (k == 201) check("mix_k201", 32'(level), {8'd0, 8'd150, 8'd10, 8'd50});
        end
        check("mix_len", 32'(n), 32'd400);
        check("mix_final", 32'(level), {8'd0, 8'd100, 8'd10, 8'd50});

        // Valid held through a fade is ignored until ready returns
        send(8'd110, 8'd10, 8'd50);
        tr = 8'd0; tg = 8'd0; tb = 8'd255; tv = 1'b1;
        n = 0; rdy_leak = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (target_ready) rdy_leak = 1'b1;
        end
        check("hs_len", 32'(n), 32'd40);
        check("hs_ready_low_busy", 32'(rdy_leak), 32'd0);
        check("hs_level_ignored", 32'(level), {8'd0, 8'd110, 8'd10, 8'd50});
        check("hs_ready_back", 32'(target_ready), 32'd1);
        @(posedge clk);
        #1 tv = 1'b0;
        check("hs_accept_busy", 32'(busy), 32'd1);
        wait_idle(n);
        check("hs_fade_len", 32'(n), 32'd820);
        check("hs_level", 32'(level), 32'h0000FF);
        send(8'd0, 8'd0, 8'd255);
        check("eq_busy", 32'(busy), 32'd0);
        check("eq_ready", 32'(target_ready), 32'd1);
        @(negedge clk);
        check("eq_busy_later", 32'(busy), 32'd0);

        // Duty 64 -> 65 changed mid-period takes effect next period only
        send(8'd64, 8'd0, 8'd255);
        wait_idle(n);
        repeat (600) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            prev = RGB_R;
            @(negedge clk);
            if (prev && !RGB_R) found = 1'b1;
        end
        check("glitch_sync", 32'(found), 32'd1);
        lo = 1;
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            lo += int'(!RGB_R);
            if (i == 100) begin
                tr = 8'd65; tg = 8'd0; tb = 8'd255; tv = 1'b1;
            end
            if (i == 101) tv = 1'b0;
        end
        check("glitch_cur_period", 32'(lo), 32'd64);
        count_low(256, lr, lg, lb);
        check("glitch_next_period", 32'(lr), 32'd65);
        check("glitch_level", 32'(level), {8'd0, 8'd65, 8'd0, 8'd255});

        // Reset halfway through a 0 -> 255 green fade
        send(8'd65, 8'd255, 8'd255);
        repeat (500) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_pins", 32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        check("midrst_ready", 32'(target_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_discard", 32'({busy, level}), 32'd0);
        send(8'd0, 8'd0, 8'd8);
        @(negedge clk);
        check("post_busy_rise", 32'(busy), 32'd1);
        wait_idle(n);
        check("post_len", 32'(n + 1), 32'd32);
        check("post_level", 32'(level), 32'h000008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Downstream LED stage for the colour sequencer. It accepts a 24-bit target colour over a valid/ready handshake.
- Ramps each channel's 8-bit intensity one LSB per step toward the target.
- Drives the board's active-low RGB LED pins with per-channel PWM.
- Replaces hard on/off colour switching with smooth, dimmable fades.

Parameters:
PWM_BITS, 8, width of intensity levels and PWM counter; PWM period = 2^PWM_BITS clk cycles
STEP_TICKS, 46875, clk cycles between fade steps (12 MHz / 46875 = 256 steps/s); must be >= 1

Ports:
clk  input  1  system clock (12 MHz on board)
rst_n  input  1  asynchronous, active-low reset
target_r  input  PWM_BITS  requested red intensity
target_g  input  PWM_BITS  requested green intensity
target_b  input  PWM_BITS  requested blue intensity
target_valid  input  1  target_r/g/b valid this cycle
target_ready  output  1  block can accept a target this cycle
busy  output  1  fade in progress
level  output  3*PWM_BITS  current intensities {r,g,b}, for debug/verification
RGB_R  output  1  red LED drive, active-low (0 = on)
RGB_G  output  1  green LED drive, active-low
RGB_B  output  1  blue LED drive, active-low

Behaviour:
- One clock domain (clk). rst_n is asynchronous assert, synchronous deassert handled by the top level.
- Reset values:
  - levels 0, targets 0, shadow duties 0.
  - pwm_cnt 0, tick counter 0, FSM IDLE.
  - RGB_R/G/B = 1 (off), target_ready = 1, busy = 0.
- PWM:
  - pwm_cnt is free-running 0..2^PWM_BITS-1 and wraps to 0.
  - Channel pin = 0 when pwm_cnt < shadow_duty, else 1. LED pins are registered outputs.
  - Level 0 means never on. Level 255 means on 255 of every 256 cycles.
  - shadow_duty is reloaded from level only in the cycle pwm_cnt == max. The new duty applies from pwm_cnt == 0, so there are no mid-period glitches.
- FSM states: IDLE, FADE.
  - target_ready = (state == IDLE), combinational from state. busy = (state == FADE).
  - IDLE: on target_valid && target_ready, latch target_r/g/b.
    - If the latched target equals the current level on all three channels, remain IDLE.
    - Otherwise go to FADE and clear the tick counter.
  - FADE: the tick counter counts 0..STEP_TICKS-1. When it reaches STEP_TICKS-1 (a step), it wraps.
    - On a step, each channel whose level differs from its target moves one LSB toward it (+1 or -1). Equal channels hold.
    - When the step makes all channels equal, go to IDLE on the same edge. target_ready is 1 the following cycle.
  - target_valid during FADE is ignored: no latch, no queueing. The upstream holds valid until it sees ready.
- Latency: acceptance to busy falling = max_channel(|target - level|) * STEP_TICKS cycles.
- Arithmetic:
  - Levels are unsigned PWM_BITS and never wrap; steps saturate at the target by construction.
  - The tick counter is $clog2(STEP_TICKS+1) bits wide. STEP_TICKS = 1 means one step per cycle.
- rst_n asserted mid-fade: immediately levels 0, pins 1, IDLE. The pending target is discarded.
- level output reflects the live level registers, not the shadow duties.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> RGB_R/G/B = 1, level = 0, target_ready = 1, busy = 0 asynchronously. No LED low pulses for 1024 cycles after release with no target.
- Single fade (STEP_TICKS = 4): send (255,0,0) -> busy high the cycle after acceptance for exactly 1020 cycles, then level = {255,0,0}. Afterwards RGB_R is low 255 of every 256 cycles; G and B stay 1.
- Mixed direction (STEP_TICKS = 4, start {200,0,50}): send (100,10,50) -> R decrements and G increments each step. G finishes after 40 cycles and holds at 10, B constant. busy drops after 400 cycles; final level {100,10,50}.
- Handshake: hold target_valid with (0,0,255) throughout a fade -> ignored while busy, accepted on the first cycle target_ready = 1. A request equal to the current level -> accepted, busy stays 0.
- Glitch-free update: level changes from 64 to 65 mid-period -> that period still has exactly 64 low cycles; the next period has 65.
- Reset mid-fade: pulse rst_n low halfway through a 0->255 green fade -> level = 0 and pins high immediately. After release, a new target (0,0,8) fades normally to {0,0,8} in 32 cycles.
